// File: rtl/usr_frame_tx_if.sv
// usr_frame_tx_if
//   Valid/ready word handshake between a parallel word producer (for example
//   the universal shift register's q output) and the serial frame transmitter.
//   Signals:
//     d_in     WIDTH  parallel word offered by the producer
//     d_valid  1      d_in holds a word to send
//     d_ready  1      consumer can accept a word this cycle
//   Modports:
//     master   producer side (drives d_in/d_valid, observes d_ready)
//     slave    consumer side (observes d_in/d_valid, drives d_ready)
interface usr_frame_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] d_in;
  logic             d_valid;
  logic             d_ready;

  modport master (output d_in, output d_valid, input d_ready);
  modport slave  (input d_in, input d_valid, output d_ready);
endinterface

// File: rtl/usr_frame_tx.sv
// usr_frame_tx
//   Accepts one parallel word per valid/ready handshake and sends it as a
//   UART-style frame on a single idle-high line:
//     start(0) | data LSB first | optional parity | STOP_BITS stop(1)
//   Each bit is held for CLKS_PER_BIT clocks.
//   Ports:
//     clk         rising-edge clock
//     reset       asynchronous, active-low reset
//     bus         usr_frame_tx_if.slave (d_in, d_valid in; d_ready out)
//     tx          serial line, idle high (registered)
//     busy        frame in progress (registered)
//     frame_done  one-cycle pulse after the last stop bit (registered)
module usr_frame_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          reset,
  usr_frame_tx_if.slave bus,
  output logic          tx,
  output logic          busy,
  output logic          frame_done
);

  // Anything other than 2 stop bits falls back to a single stop bit.
  localparam int STOP_EFF = (STOP_BITS == 2) ? 2 : 1;
  localparam int STOP_LEN = STOP_EFF * CLKS_PER_BIT;
  // The stop phase is the longest single phase, so size the counter for it.
  localparam int CW = $clog2(STOP_LEN + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic             par_reg, par_next;
  logic             tx_reg, tx_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // tx_next always carries the value of the bit that the upcoming state
  // will drive, so tx changes exactly on the bit boundary edge.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    tx_next    = tx_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        // d_ready is high in IDLE, so d_valid alone marks the transfer edge.
        if (bus.d_valid) begin
          state_next = START;
          shift_next = bus.d_in;
          par_next   = (PARITY_ODD != 0) ? ~(^bus.d_in) : (^bus.d_in);
          cnt_next   = '0;
          idx_next   = '0;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
        end
      end
      START: begin
        if (cnt_reg == BIT_LAST) begin
          state_next = DATA;
          cnt_next   = '0;
          tx_next    = shift_reg[0];
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (idx_reg == IDX_LAST) begin
            if (PARITY_EN != 0) begin
              state_next = PARITY;
              tx_next    = par_reg;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            idx_next   = idx_reg + IW'(1);
            shift_next = shift_reg >> 1;
            tx_next    = shift_next[0];
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      PARITY: begin
        if (cnt_reg == BIT_LAST) begin
          state_next = STOP;
          cnt_next   = '0;
          tx_next    = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      STOP: begin
        if (cnt_reg == STOP_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign bus.d_ready = (state_reg == IDLE);
  assign tx          = tx_reg;
  assign busy        = busy_reg;
  assign frame_done  = done_reg;

endmodule

// File: tb/tb_usr_frame_tx.sv
// tb_usr_frame_tx
//   Four transmitter instances with different configurations share clk/reset:
//     0: defaults (even parity, 1 stop, 4 clk/bit)
//     1: odd parity, 2 stop bits
//     2: no parity
//     3: 1 clk/bit
//   Table vectors plus randomized frames are checked cycle by cycle against
//   a frame model built from the bit-slot rules of the frame format.
module tb_usr_frame_tx;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] d_in_w  [4];
  logic       valid_w [4];
  logic       ready_w [4];
  logic       tx_w    [4];
  logic       busy_w  [4];
  logic       done_w  [4];

  // Configuration of each instance, used by the model.
  int cpb_c  [4] = '{4, 4, 4, 1};
  int pen_c  [4] = '{1, 1, 0, 1};
  int podd_c [4] = '{0, 1, 0, 0};
  int stop_c [4] = '{1, 2, 1, 1};

  usr_frame_tx_if #(.WIDTH(8)) bus0 ();
  usr_frame_tx_if #(.WIDTH(8)) bus1 ();
  usr_frame_tx_if #(.WIDTH(8)) bus2 ();
  usr_frame_tx_if #(.WIDTH(8)) bus3 ();

  assign bus0.d_in = d_in_w[0];  assign bus0.d_valid = valid_w[0];  assign ready_w[0] = bus0.d_ready;
  assign bus1.d_in = d_in_w[1];  assign bus1.d_valid = valid_w[1];  assign ready_w[1] = bus1.d_ready;
  assign bus2.d_in = d_in_w[2];  assign bus2.d_valid = valid_w[2];  assign ready_w[2] = bus2.d_ready;
  assign bus3.d_in = d_in_w[3];  assign bus3.d_valid = valid_w[3];  assign ready_w[3] = bus3.d_ready;

  usr_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .bus(bus0), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));
  usr_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u1 (
    .clk(clk), .reset(reset), .bus(bus1), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));
  usr_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(reset), .bus(bus2), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));
  usr_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u3 (
    .clk(clk), .reset(reset), .bus(bus3), .tx(tx_w[3]), .busy(busy_w[3]), .frame_done(done_w[3]));

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame model: slot 0 start, slots 1..8 data LSB first, slot 9 parity
  // when enabled, everything after that is stop (high).
  function automatic logic model_tx(input int s, input logic [7:0] w, input int k);
    int  slot;
    logic ones_odd;
    slot = k / cpb_c[s];
    ones_odd = ($countones(w) % 2) == 1;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return w[slot-1];
    if (pen_c[s] != 0 && slot == 9) return (podd_c[s] != 0) ? ~ones_odd : ones_odd;
    return 1'b1;
  endfunction

  function automatic int model_len(input int s);
    return (1 + 8 + pen_c[s] + stop_c[s]) * cpb_c[s];
  endfunction

  // Sends one word on instance s and checks every cycle of the frame.
  // hold: leave d_valid high at the end (back-to-back).
  // disturb: wiggle d_in/d_valid while the frame is in flight.
  task automatic send(input int s, input logic [7:0] w, input bit hold, input bit disturb,
                      output int n_meas, output int par_meas, output int xfer_cyc);
    int n_m;
    int k;
    int waitc;
    n_m = model_len(s);
    par_meas = -1;
    waitc = 0;
    while (!ready_w[s] && waitc < 200) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!ready_w[s]) chk("ready_timeout", 0, 1);
    d_in_w[s]  = w;
    valid_w[s] = 1'b1;
    @(posedge clk); #1;
    xfer_cyc = cyc;
    if (!hold) valid_w[s] = 1'b0;
    k = 0;
    while (!done_w[s] && k < 300) begin
      if (k < n_m) begin
        chk($sformatf("tx[%0d] k=%0d", s, k), int'(tx_w[s]), int'(model_tx(s, w, k)));
        chk("busy_hi", int'(busy_w[s]), 1);
        chk("ready_lo", int'(ready_w[s]), 0);
      end
      if (pen_c[s] != 0 && k == 9 * cpb_c[s]) par_meas = int'(tx_w[s]);
      if (disturb && k < n_m - 1) begin
        d_in_w[s]  = 8'($urandom);
        valid_w[s] = 1'($urandom);
      end else if (!hold) begin
        valid_w[s] = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    n_meas = k;
    chk("done_seen", int'(done_w[s]), 1);
    chk("tx_idle_at_done", int'(tx_w[s]), 1);
    chk("busy_lo_at_done", int'(busy_w[s]), 0);
    chk("ready_at_done", int'(ready_w[s]), 1);
    if (!hold) begin
      @(posedge clk); #1;
      chk("done_one_cycle", int'(done_w[s]), 0);
      chk("no_extra_frame", int'(busy_w[s]), 0);
    end
    $display("frame dut=%0d word=%02h len=%0d parity=%0d xfer@%0d", s, w, n_meas, par_meas, xfer_cyc);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] word;
    bit         hold;
    bit         disturb;
    int         exp_n;
    int         exp_par;   // -1: no parity slot
    int         exp_gap;   // 0: no spacing check against previous transfer
  } vec_t;

  vec_t vt [7];

  initial begin
    int n_meas, par_meas, xc, prev_xc;
    logic [7:0] rw;
    int rs;

    vt[0] = '{0, 8'b00011101, 1'b0, 1'b0, 44, 0, 0};
    vt[1] = '{0, 8'hA5,       1'b1, 1'b0, 44, 0, 0};
    vt[2] = '{0, 8'h3C,       1'b0, 1'b0, 44, 0, 45};
    vt[3] = '{1, 8'hFF,       1'b0, 1'b0, 48, 1, 0};
    vt[4] = '{2, 8'h01,       1'b0, 1'b0, 40, -1, 0};
    vt[5] = '{0, 8'h07,       1'b0, 1'b1, 44, 1, 0};
    vt[6] = '{3, 8'hC3,       1'b0, 1'b0, 11, 0, 0};

    for (int i = 0; i < 4; i++) begin
      d_in_w[i]  = 8'h00;
      valid_w[i] = 1'b0;
    end

    // Reset held with d_valid high: nothing may start.
    valid_w[0] = 1'b1;
    d_in_w[0]  = 8'h00;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("rst_tx", int'(tx_w[0]), 1);
      chk("rst_busy", int'(busy_w[0]), 0);
      chk("rst_done", int'(done_w[0]), 0);
      chk("rst_ready", int'(ready_w[0]), 1);
      $display("reset cycle %0d tx=%0d busy=%0d ready=%0d", c, tx_w[0], busy_w[0], ready_w[0]);
    end
    valid_w[0] = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", int'(busy_w[0]), 0);

    prev_xc = 0;
    for (int i = 0; i < 7; i++) begin
      send(vt[i].sel, vt[i].word, vt[i].hold, vt[i].disturb, n_meas, par_meas, xc);
      chk($sformatf("vec%0d_len", i), n_meas, vt[i].exp_n);
      chk($sformatf("vec%0d_par", i), par_meas, vt[i].exp_par);
      if (vt[i].exp_gap != 0) chk($sformatf("vec%0d_gap", i), xc - prev_xc, vt[i].exp_gap);
      prev_xc = xc;
    end

    // Reset pulse during data bit 3 of a frame on instance 0.
    d_in_w[0]  = 8'hF0;
    valid_w[0] = 1'b1;
    @(posedge clk); #1;
    valid_w[0] = 1'b0;
    repeat (17) begin
      @(posedge clk); #1;
    end
    chk("pre_abort_busy", int'(busy_w[0]), 1);
    reset = 1'b0;
    #1;
    chk("abort_tx", int'(tx_w[0]), 1);
    chk("abort_busy", int'(busy_w[0]), 0);
    chk("abort_done", int'(done_w[0]), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      chk("abort_no_done", int'(done_w[0]), 0);
    end
    $display("reset abort checked, busy=%0d", busy_w[0]);
    send(0, 8'h55, 1'b0, 1'b0, n_meas, par_meas, xc);
    chk("after_abort_len", n_meas, 44);
    chk("after_abort_par", par_meas, 0);

    // Randomized frames on random instances.
    for (int i = 0; i < 40; i++) begin
      rs = int'($urandom_range(0, 3));
      rw = 8'($urandom);
      send(rs, rw, 1'b0, bit'($urandom_range(0, 1)), n_meas, par_meas, xc);
      chk("rand_len", n_meas, model_len(rs));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
